tv_recorder: RTL and testbench
==============================

# tv_recorder

- Captures a stream of test vectors (stimulus bits plus the observed response bit) into an internal vector memory.
- Plays the captured vectors back over a valid/ready stream.
- Pairs with the vector-driven gate benches as the writer side: it records DUT behaviour into the 3-bit `{a, b, expected}` format those benches consume, so golden vector sets can be generated in simulation or on-board.
- Sits beside the DUT, sampling the DUT's inputs and output once per clock.

## Interface
Parameters:
- `WIDTH`, 3: bits per vector (`{a, b, y}`).
- `DEPTH`, 31: number of vector slots.
- `PTR_W`, 5: pointer/count width. Must satisfy DEPTH ≤ 2^PTR_W − 1.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a new recording (honoured only in IDLE).
- `stop`  in  1  end recording early (honoured only in REC).
- `sample_en`  in  1  store `vec_in` this cycle (REC only).
- `vec_in`  in  WIDTH  vector to capture, `{a, b, y}` MSB first.
- `dump_req`  in  1  begin playback (honoured only in DONE).
- `vec_out`  out  WIDTH  playback vector.
- `vec_valid`  out  1  `vec_out` valid.
- `vec_ready`  in  1  consumer accepts `vec_out`.
- `vec_count`  out  PTR_W  number of vectors stored.
- `busy`  out  1  state ≠ IDLE.
- `full`  out  1  `vec_count` == DEPTH.
- `done`  out  1  one-cycle pulse at end of playback.

## Operation
- **FSM states:** IDLE, REC, DONE, DUMP.
- **IDLE**
  - `start` = 1: `wr_ptr` ← 0, `vec_count` ← 0, `full` ← 0, next state REC.
- **REC**
  - `sample_en` = 1: `mem[wr_ptr]` ← `vec_in`, `wr_ptr` and `vec_count` increment.
  - Storing the DEPTH-th vector: `full` ← 1, next state DONE. Further `sample_en` is ignored.
  - `stop` = 1: next state DONE. A sample presented in the same cycle is still stored.
- **DONE**
  - Holds the contents.
  - `dump_req` = 1 with `vec_count` > 0: `rd_ptr` ← 0, next state DUMP.
  - `dump_req` = 1 with `vec_count` == 0: `done` pulses, next state IDLE.
  - `start` is ignored.
- **DUMP**
  - `vec_valid` = 1 and `vec_out` = `mem[rd_ptr]` (combinational read).
  - On `vec_valid` & `vec_ready`: `rd_ptr` increments.
  - When the vector at `rd_ptr` == `vec_count` − 1 is accepted: `done` pulses for one cycle, next state IDLE.
  - `vec_out` and `vec_valid` hold while `vec_ready` = 0.
- **In all states**
  - `start`, `stop` and `dump_req` outside their honouring state have no effect.
  - `vec_count` and the memory remain readable and unchanged after returning to IDLE until the next `start`.
- **Arithmetic:** pointers and count are unsigned PTR_W-bit values. They never wrap, because the FSM leaves REC at DEPTH and leaves DUMP at `vec_count`.

## Timing
- **Reset** (asynchronous, takes effect immediately):
  - State IDLE.
  - `vec_out` = 0, `vec_valid` = 0, `vec_count` = 0, `busy` = 0, `full` = 0, `done` = 0.
  - Pointers 0. Memory contents are not cleared.
- **Reset mid-REC or mid-DUMP:** aborts the operation. Outputs take their reset values; no `done` pulse.
- **State entry:** one cycle after the honoured control input.
  - `busy` rises the cycle after `start`.
  - `vec_valid` rises the cycle after `dump_req`.
- **Capture latency:** sample presented in cycle N is written at the rising edge ending cycle N. `vec_count` reflects it in cycle N+1.
- **Playback throughput:** one vector per cycle while `vec_ready` is held high. `done` is asserted in the cycle after the final handshake, coincident with `vec_valid` = 0.
- **Simultaneous `start` and `stop` in IDLE:** `start` is honoured, `stop` is ignored.

## Configuration
- Macro `TV_REC_DEDUP_EN`.
- **Defined:** in REC, a sample with `vec_count` > 0 and `vec_in` equal to the most recently stored vector is dropped. No write, no count increment. Its `stop` is still honoured.
- **Undefined:** every `sample_en` cycle in REC is stored unconditionally.

## Test plan
- **Reset during REC:** `start`, sample 5 vectors, assert `reset` mid-cycle. Required: outputs go to reset values immediately; after release, state is IDLE with `vec_count` = 0.
- **Full capture and replay:** `start`, then 31 consecutive samples of `{a, b, a^b}` cycling 000, 011, 101, 110. Required: `full` = 1 and state DONE after the 31st sample, and a 32nd sample is ignored. `dump_req` with `vec_ready` = 1 then yields 31 vectors on consecutive cycles in the same order, followed by a one-cycle `done`.
- **Early stop with backpressure:** `start`, sample 100 and 111, with `stop` coincident with the second sample. Required: `vec_count` = 2. During DUMP, `vec_ready` toggles 0,1,0,1 and `vec_out` holds 100 until the first accept, then 111.
- **Zero-length recording:** `start` then `stop` with no samples, then `dump_req`. Required: `vec_valid` never asserts, `done` pulses, state returns to IDLE.
- **Ignored controls:** `start` in DONE and `dump_req` in REC. Required: no state change and `vec_count` unchanged.
- **With `TV_REC_DEDUP_EN`:** samples 011, 011, 101, 101, 011. Required: `vec_count` = 3 and playback 011, 101, 011. Without the macro: `vec_count` = 5.

Source files
------------

// File: rtl/tv_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tv_recorder
// Function : Captures {a,b,y} test vectors into memory and replays them over valid/ready.
// Options  : TV_REC_DEDUP_EN drops a sample equal to the last stored vector.
// Revision : 1.0 - initial release
// ============================================================================
module tv_recorder #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 31,
    parameter int PTR_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             sample_en_i,
    input  logic [WIDTH-1:0] vec_in_i,
    input  logic             dump_req_i,
    output logic [WIDTH-1:0] vec_out_o,
    output logic             vec_valid_o,
    input  logic             vec_ready_i,
    output logic [PTR_W-1:0] vec_count_o,
    output logic             busy_o,
    output logic             full_o,
    output logic             done_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_DUMP = 2'd3;

    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] C_ONE  = PTR_W'(1);

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic w_dup;
    logic w_store;
    logic w_accept;
    logic w_rd_last;

`ifdef TV_REC_DEDUP_EN
    assign w_dup = (count_q != '0) && (vec_in_i == mem[count_q - C_ONE]);
`else
    assign w_dup = 1'b0;
`endif

    assign w_store   = (state_q == S_REC) && sample_en_i && !w_dup;
    assign w_accept  = (state_q == S_DUMP) && vec_ready_i;
    assign w_rd_last = (rd_ptr_q == (count_q - C_ONE));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_REC;
            S_REC: begin
                if (stop_i || (w_store && (count_q == C_LAST))) state_d = S_DONE;
            end
            S_DONE: begin
                if (dump_req_i) state_d = (count_q != '0) ? S_DUMP : S_IDLE;
            end
            S_DUMP: if (w_accept && w_rd_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != S_IDLE);
        vec_valid_o = (state_q == S_DUMP);
        vec_out_o   = vec_valid_o ? mem[rd_ptr_q] : '0;
    end

    always_comb begin
        count_d  = count_q;
        full_d   = full_q;
        rd_ptr_d = rd_ptr_q;
        done_d   = 1'b0;
        if ((state_q == S_IDLE) && start_i) begin
            count_d = '0;
            full_d  = 1'b0;
        end
        if (w_store) begin
            count_d = count_q + C_ONE;
            if (count_q == C_LAST) full_d = 1'b1;
        end
        if ((state_q == S_DONE) && dump_req_i) begin
            rd_ptr_d = '0;
            done_d   = (count_q == '0);
        end
        if (w_accept) begin
            rd_ptr_d = rd_ptr_q + C_ONE;
            done_d   = w_rd_last;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            done_q   <= done_d;
        end
    end

    // Vector storage survives reset so a capture can still be inspected afterwards.
    always_ff @(posedge clk_i) begin
        if (w_store) mem[count_q] <= vec_in_i;
    end

    assign vec_count_o = count_q;
    assign full_o      = full_q;
    assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_tv_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tv_recorder
// Function : Directed and random bench for tv_recorder against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tv_recorder;

    localparam int WIDTH = 3;
    localparam int DEPTH = 31;
    localparam int PTR_W = 5;

    localparam int M_IDLE = 0;
    localparam int M_REC  = 1;
    localparam int M_DONE = 2;
    localparam int M_DUMP = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic             sample_en;
    logic [WIDTH-1:0] vec_in;
    logic             dump_req;
    logic [WIDTH-1:0] vec_out;
    logic             vec_valid;
    logic             vec_ready;
    logic [PTR_W-1:0] vec_count;
    logic             busy;
    logic             full;
    logic             done;

    tv_recorder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .stop_i      (stop),
        .sample_en_i (sample_en),
        .vec_in_i    (vec_in),
        .dump_req_i  (dump_req),
        .vec_out_o   (vec_out),
        .vec_valid_o (vec_valid),
        .vec_ready_i (vec_ready),
        .vec_count_o (vec_count),
        .busy_o      (busy),
        .full_o      (full),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    int               total = 0;
    int               bad   = 0;
    int               m_mode;
    int               m_rd;
    bit               m_done;
    logic [WIDTH-1:0] m_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [WIDTH-1:0] e_out;
        e_out = (m_mode == M_DUMP) ? m_q[m_rd] : '0;
        chk({tag, ":busy"},  32'(busy),      32'(m_mode != M_IDLE));
        chk({tag, ":valid"}, 32'(vec_valid), 32'(m_mode == M_DUMP));
        chk({tag, ":out"},   32'(vec_out),   32'(e_out));
        chk({tag, ":count"}, 32'(vec_count), 32'(m_q.size()));
        chk({tag, ":full"},  32'(full),      32'(m_q.size() == DEPTH));
        chk({tag, ":done"},  32'(done),      32'(m_done));
    endtask

    // Abstract model: recorded vectors live in a queue, playback walks an index.
    task automatic model_edge();
        bit dup;
        bit nd;
        dup = 1'b0;
        nd  = 1'b0;
        case (m_mode)
            M_IDLE: if (start) begin
                m_q.delete();
                m_mode = M_REC;
            end
            M_REC: begin
`ifdef TV_REC_DEDUP_EN
                dup = (m_q.size() > 0) && (vec_in == m_q[$]);
`endif
                if (sample_en && !dup) m_q.push_back(vec_in);
                if (stop || (m_q.size() == DEPTH)) m_mode = M_DONE;
            end
            M_DONE: if (dump_req) begin
                if (m_q.size() > 0) begin
                    m_mode = M_DUMP;
                    m_rd   = 0;
                end else begin
                    nd     = 1'b1;
                    m_mode = M_IDLE;
                end
            end
            default: if (vec_ready) begin
                m_rd++;
                if (m_rd == m_q.size()) begin
                    nd     = 1'b1;
                    m_mode = M_IDLE;
                end
            end
        endcase
        m_done = nd;
    endtask

    task automatic cyc(input logic st, input logic sp, input logic se,
                       input logic [WIDTH-1:0] v, input logic dr, input logic rd,
                       input string tag);
        start     = st;
        stop      = sp;
        sample_en = se;
        vec_in    = v;
        dump_req  = dr;
        vec_ready = rd;
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset(input string tag);
        #2;
        reset     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        sample_en = 1'b0;
        vec_in    = '0;
        dump_req  = 1'b0;
        vec_ready = 1'b0;
        m_mode    = M_IDLE;
        m_rd      = 0;
        m_done    = 1'b0;
        m_q.delete();
        #1;
        check_all({tag, "_asserted"});
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_all({tag, "_released"});
    endtask

    // Runs playback to completion; rmode 1 = always ready, 0 = random ready.
    task automatic drain(input bit rmode, input string tag);
        int budget;
        budget = 0;
        while (m_mode == M_DUMP && budget < 300) begin
            cyc(0, 0, 0, '0, 0, rmode ? 1'b1 : 1'($urandom_range(0, 1)), tag);
            budget++;
        end
        if (m_mode == M_DUMP) begin
            total++;
            bad++;
            $error("FAIL %s_timeout observed=busy expected=idle", tag);
        end
        cyc(0, 0, 0, '0, 0, 0, {tag, "_end"});
        cyc(0, 0, 0, '0, 0, 0, {tag, "_after"});
    endtask

    initial begin
        logic [WIDTH-1:0] pat[4];
        logic [WIDTH-1:0] ded[5];
        pat[0] = 3'b000; pat[1] = 3'b011; pat[2] = 3'b101; pat[3] = 3'b110;
        ded[0] = 3'b011; ded[1] = 3'b011; ded[2] = 3'b101; ded[3] = 3'b101; ded[4] = 3'b011;

        do_reset("por");

        // Reset while recording.
        cyc(1, 0, 0, '0, 0, 0, "rrec_start");
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 3'($urandom), 0, 0, "rrec_sample");
        do_reset("rst_midrec");
        chk("rst_midrec_count", 32'(vec_count), 32'd0);

        // Full capture and in-order replay.
        cyc(1, 0, 0, '0, 0, 0, "full_start");
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, pat[i % 4], 0, 0, "full_fill");
        chk("full_flag", 32'(full), 32'd1);
        cyc(0, 0, 1, 3'b111, 0, 0, "full_extra");
        cyc(1, 0, 0, '0, 0, 0, "start_in_done");
        chk("start_in_done_count", 32'(vec_count), 32'd31);
        cyc(0, 0, 0, '0, 1, 1, "full_dump_req");
        drain(1'b1, "full_dump");

        // Early stop with backpressure.
        cyc(1, 0, 0, '0, 0, 0, "early_start");
        cyc(0, 0, 1, 3'b100, 0, 0, "early_s0");
        cyc(0, 1, 1, 3'b111, 0, 0, "early_s1");
        chk("early_count", 32'(vec_count), 32'd2);
        cyc(0, 0, 0, '0, 1, 0, "early_dump_req");
        cyc(0, 0, 0, '0, 0, 0, "early_bp0");
        chk("early_hold", 32'(vec_out), 32'b100);
        cyc(0, 0, 0, '0, 0, 1, "early_bp1");
        cyc(0, 0, 0, '0, 0, 0, "early_bp2");
        chk("early_second", 32'(vec_out), 32'b111);
        cyc(0, 0, 0, '0, 0, 1, "early_bp3");
        chk("early_done", 32'(done), 32'd1);
        cyc(0, 0, 0, '0, 0, 0, "early_idle");

        // Zero-length recording.
        cyc(1, 0, 0, '0, 0, 0, "zero_start");
        cyc(0, 1, 0, '0, 0, 1, "zero_stop");
        cyc(0, 0, 0, '0, 1, 1, "zero_dump_req");
        chk("zero_done", 32'(done), 32'd1);
        cyc(0, 0, 0, '0, 0, 1, "zero_idle");

        // dump_req while recording is ignored.
        cyc(1, 0, 0, '0, 0, 0, "drec_start");
        cyc(0, 0, 1, 3'b010, 1, 1, "drec_dump");
        cyc(0, 0, 1, 3'b001, 1, 1, "drec_dump2");
        chk("drec_count", 32'(vec_count), 32'd2);
        cyc(0, 1, 0, '0, 0, 0, "drec_stop");
        cyc(0, 0, 0, '0, 1, 1, "drec_dump_req");
        drain(1'b1, "drec_dump");

        // Duplicate-sample sequence.
        cyc(1, 0, 0, '0, 0, 0, "dedup_start");
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, ded[i], 0, 0, "dedup_sample");
`ifdef TV_REC_DEDUP_EN
        chk("dedup_count", 32'(vec_count), 32'd3);
`else
        chk("dedup_count", 32'(vec_count), 32'd5);
`endif
        cyc(0, 1, 0, '0, 0, 0, "dedup_stop");
        cyc(0, 0, 0, '0, 1, 1, "dedup_dump_req");
        drain(1'b1, "dedup_dump");

        // Random recordings with noise controls and random backpressure.
        for (int r = 0; r < 8; r++) begin
            int budget;
            budget = 0;
            cyc(1, (r == 0), 0, '0, 0, 0, "rnd_start");
            while (m_mode == M_REC && budget < 60) begin
                cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0),
                    ($urandom_range(0, 3) != 0), 3'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd_rec");
                budget++;
            end
            if (m_mode == M_REC) cyc(0, 1, 0, '0, 0, 0, "rnd_stop");
            cyc(0, 0, 0, '0, 1, 1'($urandom_range(0, 1)), "rnd_dump_req");
            drain(1'b0, "rnd_dump");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
